mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Responder end of the CPU's byte-wide memory bus: services every `mem_a`/`mem_wr`/`mem_dout` transaction the core issues, returning read data on `mem_din` one cycle later. It contains the 128 KB data/instruction RAM, the memory-mapped I/O port at 0x30000–0x30007, a UART transmit FIFO that drives `io_buffer_full` back to the core, a free-running cycle counter and the program-stop sequencer. It sits beside the CPU at the top level, between the core and the UART.

## Interface
- `ADDR_WIDTH`, 17: RAM byte-address width (2^17 bytes).
- `TX_DEPTH_BIT`, 3: log2 of TX FIFO depth (default 8 entries).
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `mem_a`  in  32  byte address from core; only [17:0] decoded.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_dout`  in  8  write data from core.
- `mem_din`  out  8  read data to core, valid the cycle after the request.
- `io_buffer_full`  out  1  TX FIFO near full; core must not issue I/O writes.
- `tx_data`  out  8  byte to UART transmitter.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  UART accepts `tx_data` this cycle.
- `rx_data`  in  8  received byte (only with RX enabled).
- `rx_valid`  in  1  `rx_data` holds an unread byte.
- `rx_pop`  out  1  one-cycle pulse: byte consumed.
- `program_finished`  out  1  sticky; stop sequence complete.
- `tx_overflow`  out  1  sticky; a push hit a full FIFO.

## Operation
- Decode: I/O when `mem_a[17:16]==2'b11`, else RAM at `mem_a[ADDR_WIDTH-1:0]`.
- RAM write: `ram[addr] <= mem_dout` at edge when `mem_wr`. RAM read: `mem_din <= ram[addr]`. RAM contents not affected by reset.
- I/O read 0x30000: `mem_din <=` `rx_data` if `rx_valid` (and `rx_pop` pulses the same edge), else 0x00.
- I/O read 0x30004: captures `snap <= cycle_cnt` and returns `cycle_cnt[7:0]`; reads 0x30005/6/7 return `snap[15:8]`, `[23:16]`, `[31:24]`.
- I/O write 0x30000: push `mem_dout` if nonzero; zero ignored.
- I/O write 0x30004: push 0x00 (always) and enter STOPPING.
- Other I/O offsets: reads return 0x00, writes ignored.
- Push into a full FIFO is dropped and sets `tx_overflow`.
- FIFO: `tx_valid = count!=0`, `tx_data = head`; pop on `tx_valid && tx_ready`. Simultaneous push and pop leaves count unchanged, and is legal when full (pop frees the slot).
- `io_buffer_full = count >= 2^TX_DEPTH_BIT - 2` (combinational; two-entry margin for writes already in flight).
- Stop FSM: RUN → STOPPING on write to 0x30004; STOPPING → HALTED when FIFO empty after the 0x00 has popped. HALTED is terminal until reset. In STOPPING/HALTED, I/O writes are ignored; RAM and reads still work. `program_finished = (state==HALTED)`.
- `cycle_cnt`: 32-bit, +1 every clock from reset, wraps at 2^32.

## Timing
- Reset values: `mem_din`=0, `tx_valid`=0, `tx_data`=0, `rx_pop`=0, `io_buffer_full`=0, `program_finished`=0, `tx_overflow`=0, count/pointers=0, `cycle_cnt`=0, `snap`=0, state RUN.
- Reset mid-operation clears the FIFO (queued bytes lost) and aborts STOPPING.
- Read latency is exactly 1 cycle, and a new request is accepted every cycle. Reads and writes are never stalled.
- A pushed byte appears on `tx_valid` the cycle after the write edge.
- `io_buffer_full` reflects the post-edge count.
- FIFO pointers wrap modulo depth.

## Configuration
- `MEM_IO_RX_EN` defined: 0x30000 reads return `rx_data` and drive `rx_pop` as above.
- Undefined: `rx_data`/`rx_valid` ignored, 0x30000 reads return 0x00, and `rx_pop` is tied to 0.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 → `mem_din`=0xA5 exactly one cycle after the read request; back-to-back reads of 0x0/0x1 return bytes in consecutive cycles.
- Write 'H','i',0x00 to 0x30000 with `tx_ready`=1 → `tx_data` emits 0x48 then 0x69; the zero is never queued.
- Hold `tx_ready`=0 and write 6 nonzero bytes (depth 8) → `io_buffer_full` rises after the 6th; 9th write sets `tx_overflow`, count stays 8.
- Read 0x30004 at `cycle_cnt`=0x00001234, then 0x30005 → returns 0x34, then 0x12 (snapshot, not live).
- Queue 'A', write 0x30004, release `tx_ready` → UART sees 0x41, 0x00; `program_finished` rises the cycle after FIFO empties; a later write to 0x30000 is ignored.
- With `MEM_IO_RX_EN`, `rx_valid`=1, `rx_data`=0x37, read 0x30000 → `mem_din`=0x37 and a single `rx_pop` pulse; with `rx_valid`=0 → 0x00 and no pulse.

Source files
------------

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: 128 KB RAM, I/O port, UART TX FIFO, cycle counter, stop sequencer.
// Optional RX read path on 0x30000 is built only when MEM_IO_RX_EN is defined.
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_BIT = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_finished,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << TX_DEPTH_BIT;
    localparam int CW    = TX_DEPTH_BIT + 1;

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_NEAR  = CW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TX_DEPTH_BIT-1:0] PTR_ONE = TX_DEPTH_BIT'(1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_STOP = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [15:0] OFF_DATA = 16'h0000;
    localparam logic [15:0] OFF_CNT0 = 16'h0004;
    localparam logic [15:0] OFF_CNT1 = 16'h0005;
    localparam logic [15:0] OFF_CNT2 = 16'h0006;
    localparam logic [15:0] OFF_CNT3 = 16'h0007;

    // Address decode
    logic                  is_io;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           io_off;
    logic                  io_rd;
    logic                  io_wr;

    assign is_io    = (mem_a[17:16] == 2'b11);
    assign ram_addr = mem_a[ADDR_WIDTH-1:0];
    assign io_off   = mem_a[15:0];
    assign io_rd    = is_io && !mem_wr;
    assign io_wr    = is_io && mem_wr;

    // RAM is not reset; its read register is qualified by src_ram_q instead
    logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] ram_rdata_q;

    always_ff @(posedge clk_in) begin
        if (!is_io && mem_wr) begin
            ram[ram_addr] <= mem_dout;
        end
        ram_rdata_q <= ram[ram_addr];
    end

    // Registered state
    logic [1:0]              state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             snap_q, snap_d;
    logic                    src_ram_q, src_ram_d;
    logic [7:0]              io_rdata_q, io_rdata_d;
    logic                    rx_pop_q, rx_pop_d;
    logic                    ovf_q, ovf_d;
    logic [CW-1:0]           count_q, count_d;
    logic [TX_DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [TX_DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]              fifo_q [DEPTH];
    logic [7:0]              fifo_d [DEPTH];

    // Read path
    always_comb begin
        src_ram_d  = !is_io && !mem_wr;
        io_rdata_d = 8'h00;
        rx_pop_d   = 1'b0;
        snap_d     = snap_q;
        if (io_rd) begin
            case (io_off)
                OFF_DATA: begin
`ifdef MEM_IO_RX_EN
                    if (rx_valid) begin
                        io_rdata_d = rx_data;
                        rx_pop_d   = 1'b1;
                    end
`endif
                end
                OFF_CNT0: begin
                    io_rdata_d = cnt_q[7:0];
                    snap_d     = cnt_q;
                end
                OFF_CNT1: io_rdata_d = snap_q[15:8];
                OFF_CNT2: io_rdata_d = snap_q[23:16];
                OFF_CNT3: io_rdata_d = snap_q[31:24];
                default:  io_rdata_d = 8'h00;
            endcase
        end
    end

`ifdef MEM_IO_RX_EN
    logic unused_ok;
    assign unused_ok = ^mem_a[31:18];
`else
    logic unused_ok;
    assign unused_ok = ^{mem_a[31:18], rx_data, rx_valid};
`endif

    assign cnt_d = cnt_q + 32'd1;

    // TX FIFO and stop sequencer
    logic       wr_run;
    logic       push_req;
    logic       wr_stop;
    logic       pop;
    logic       full;
    logic       push_ok;
    logic [7:0] push_data;

    assign wr_run    = io_wr && (state_q == ST_RUN);
    assign wr_stop   = wr_run && (io_off == OFF_CNT0);
    assign push_req  = wr_stop ||
                       (wr_run && (io_off == OFF_DATA) && (mem_dout != 8'h00));
    assign push_data = wr_stop ? 8'h00 : mem_dout;
    assign pop       = tx_valid && tx_ready;
    assign full      = (count_q == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok   = push_req && (!full || pop);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (wr_stop) state_d = ST_STOP;
            ST_STOP: if (count_q == '0) state_d = ST_HALT;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_RUN;
            cnt_q      <= 32'd0;
            snap_q     <= 32'd0;
            src_ram_q  <= 1'b0;
            io_rdata_q <= 8'h00;
            rx_pop_q   <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_q     <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            src_ram_q  <= src_ram_d;
            io_rdata_q <= io_rdata_d;
            rx_pop_q   <= rx_pop_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
        end
    end

    // Outputs
    assign mem_din          = src_ram_q ? ram_rdata_q : io_rdata_q;
    assign tx_valid         = (count_q != '0);
    assign tx_data          = fifo_q[rd_ptr_q];
    assign io_buffer_full   = (count_q >= CNT_NEAR);
    assign rx_pop           = rx_pop_q;
    assign program_finished = (state_q == ST_HALT);
    assign tx_overflow      = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder: RAM, TX FIFO, cycle snapshot, stop sequence, RX port.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_mem_io_responder;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_finished;
    logic        tx_overflow;

    int tests_run;
    int tests_failed;

    mem_io_responder dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .mem_dout         (mem_dout),
        .mem_din          (mem_din),
        .io_buffer_full   (io_buffer_full),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_pop           (rx_pop),
        .program_finished (program_finished),
        .tx_overflow      (tx_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        mem_a    = 32'h0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = 1'b1;
        mem_dout = d;
        step();
        idle();
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_a  = a;
        mem_wr = 1'b0;
        step();
        idle();
    endtask

    task automatic reset_dut();
        idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_in   = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests_run++;
        if (mem_din !== 8'h00) begin tests_failed++; $display("FAIL rst_mem_din: got %02h want 00", mem_din); end
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %02h want 00", tx_data); end
        tests_run++;
        if (rx_pop !== 1'b0) begin tests_failed++; $display("FAIL rst_rx_pop: got %b want 0", rx_pop); end
        tests_run++;
        if (io_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL rst_iobf: got %b want 0", io_buffer_full); end
        tests_run++;
        if (program_finished !== 1'b0) begin tests_failed++; $display("FAIL rst_pf: got %b want 0", program_finished); end
        tests_run++;
        if (tx_overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf: got %b want 0", tx_overflow); end
    endtask

    task automatic test_ram();
        reset_dut();
        bus_write(32'h0000_0010, 8'hA5);
        bus_write(32'h0000_0000, 8'h11);
        bus_write(32'h0000_0001, 8'h22);
        bus_read(32'h0000_0010);
        tests_run++;
        if (mem_din !== 8'hA5) begin tests_failed++; $display("FAIL ram_rd_10: got %02h want a5", mem_din); end
        mem_a = 32'h0;
        step();
        tests_run++;
        if (mem_din !== 8'h11) begin tests_failed++; $display("FAIL ram_b2b_0: got %02h want 11", mem_din); end
        mem_a = 32'h1;
        step();
        tests_run++;
        if (mem_din !== 8'h22) begin tests_failed++; $display("FAIL ram_b2b_1: got %02h want 22", mem_din); end
        idle();
    endtask

    task automatic test_tx();
        reset_dut();
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'h48);
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
            tests_failed++; $display("FAIL tx_h: got v=%b d=%02h want v=1 d=48", tx_valid, tx_data);
        end
        bus_write(32'h0003_0000, 8'h69);
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin
            tests_failed++; $display("FAIL tx_i: got v=%b d=%02h want v=1 d=69", tx_valid, tx_data);
        end
        bus_write(32'h0003_0000, 8'h00);
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_zero: got v=%b want 0", tx_valid); end
        step();
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_zero_late: got v=%b want 0", tx_valid); end
    endtask

    task automatic test_fill();
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            bus_write(32'h0003_0000, 8'h10 + 8'(i));
            if (i == 5) begin
                tests_run++;
                if (io_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL fill_iobf5: got %b want 0", io_buffer_full); end
            end
        end
        tests_run++;
        if (io_buffer_full !== 1'b1) begin tests_failed++; $display("FAIL fill_iobf6: got %b want 1", io_buffer_full); end
        bus_write(32'h0003_0000, 8'h17);
        bus_write(32'h0003_0000, 8'h18);
        tests_run++;
        if (tx_overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf8: got %b want 0", tx_overflow); end
        bus_write(32'h0003_0000, 8'h19);
        tests_run++;
        if (tx_overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_ovf9: got %b want 1", tx_overflow); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
                tests_failed++;
                $display("FAIL drain_%0d: got v=%b d=%02h want v=1 d=%02h", i, tx_valid, tx_data, 8'h10 + 8'(i));
            end
            step();
        end
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got v=%b want 0", tx_valid); end
        tests_run++;
        if (tx_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", tx_overflow); end
    endtask

    task automatic test_snapshot();
        reset_dut();
        repeat (32'h1234) step();
        bus_read(32'h0003_0004);
        tests_run++;
        if (mem_din !== 8'h34) begin tests_failed++; $display("FAIL snap_b0: got %02h want 34", mem_din); end
        bus_read(32'h0003_0005);
        tests_run++;
        if (mem_din !== 8'h12) begin tests_failed++; $display("FAIL snap_b1: got %02h want 12", mem_din); end
        repeat (32'h100) step();
        bus_read(32'h0003_0005);
        tests_run++;
        if (mem_din !== 8'h12) begin tests_failed++; $display("FAIL snap_hold: got %02h want 12", mem_din); end
        bus_read(32'h0003_0007);
        tests_run++;
        if (mem_din !== 8'h00) begin tests_failed++; $display("FAIL snap_b3: got %02h want 00", mem_din); end
        bus_read(32'h0003_0004);
        tests_run++;
        if (mem_din !== 8'h38) begin tests_failed++; $display("FAIL snap2_b0: got %02h want 38", mem_din); end
        bus_read(32'h0003_0005);
        tests_run++;
        if (mem_din !== 8'h13) begin tests_failed++; $display("FAIL snap2_b1: got %02h want 13", mem_din); end
    endtask

    task automatic test_stop();
        reset_dut();
        bus_write(32'h0003_0000, 8'h41);
        bus_write(32'h0003_0004, 8'hFF);
        bus_write(32'h0003_0000, 8'h51);
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41 || program_finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_q: got v=%b d=%02h pf=%b want v=1 d=41 pf=0", tx_valid, tx_data, program_finished);
        end
        tx_ready = 1'b1;
        step();
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            tests_failed++; $display("FAIL stop_zero: got v=%b d=%02h want v=1 d=00", tx_valid, tx_data);
        end
        step();
        tests_run++;
        if (tx_valid !== 1'b0 || program_finished !== 1'b0) begin
            tests_failed++; $display("FAIL stop_empty: got v=%b pf=%b want v=0 pf=0", tx_valid, program_finished);
        end
        step();
        tests_run++;
        if (program_finished !== 1'b1) begin tests_failed++; $display("FAIL stop_pf: got %b want 1", program_finished); end
        bus_write(32'h0003_0000, 8'h5A);
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_wr: got v=%b want 0", tx_valid); end
        bus_write(32'h0000_0100, 8'h5A);
        bus_read(32'h0000_0100);
        tests_run++;
        if (mem_din !== 8'h5A || program_finished !== 1'b1) begin
            tests_failed++; $display("FAIL halt_ram: got d=%02h pf=%b want d=5a pf=1", mem_din, program_finished);
        end
    endtask

    task automatic test_misc_io();
        reset_dut();
        bus_write(32'h0001_0010, 8'h77);
        bus_read(32'h0003_0010);
        tests_run++;
        if (mem_din !== 8'h00) begin tests_failed++; $display("FAIL io_unmapped_rd: got %02h want 00", mem_din); end
        bus_read(32'h0001_0010);
        tests_run++;
        if (mem_din !== 8'h77) begin tests_failed++; $display("FAIL ram_hi_rd: got %02h want 77", mem_din); end
        bus_write(32'h0003_0001, 8'h55);
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL io_unmapped_wr: got v=%b want 0", tx_valid); end
    endtask

    task automatic test_rx();
        logic [7:0] exp_d;
        logic       exp_p;
`ifdef MEM_IO_RX_EN
        exp_d = 8'h37;
        exp_p = 1'b1;
`else
        exp_d = 8'h00;
        exp_p = 1'b0;
`endif
        reset_dut();
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        bus_read(32'h0003_0000);
        tests_run++;
        if (mem_din !== exp_d || rx_pop !== exp_p) begin
            tests_failed++;
            $display("FAIL rx_valid_rd: got d=%02h p=%b want d=%02h p=%b", mem_din, rx_pop, exp_d, exp_p);
        end
        rx_valid = 1'b0;
        step();
        tests_run++;
        if (rx_pop !== 1'b0) begin tests_failed++; $display("FAIL rx_pulse: got %b want 0", rx_pop); end
        bus_read(32'h0003_0000);
        tests_run++;
        if (mem_din !== 8'h00 || rx_pop !== 1'b0) begin
            tests_failed++; $display("FAIL rx_empty_rd: got d=%02h p=%b want d=00 p=0", mem_din, rx_pop);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            bus_write(32'h0003_0000, 8'h61 + 8'(i));
        end
        bus_write(32'h0003_0004, 8'h00);
        bus_read(32'h0003_0004);
        rst_in = 1'b1;
        #1;
        tests_run++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0 || mem_din !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_rst: got v=%b iobf=%b d=%02h want 0 0 00", tx_valid, io_buffer_full, mem_din);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        bus_write(32'h0003_0000, 8'h4B);
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h4B || program_finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_run: got v=%b d=%02h pf=%b want v=1 d=4b pf=0", tx_valid, tx_data, program_finished);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_in       = 1'b1;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        idle();
        test_reset();
        test_ram();
        test_tx();
        test_fill();
        test_snapshot();
        test_stop();
        test_misc_io();
        test_rx();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
